// File: rtl/vliw_pipe_pkg.sv
// rtl/vliw_pipe_pkg.sv - shared types and defaults for VLIW inter-stage registers
package vliw_pipe_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 64;
  localparam int PC_W_DEF   = 32;

  localparam logic [LANES_DEF-1:0] NOP_ALL = {LANES_DEF{1'b1}};

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t;

  // Bundle at the default pipeline geometry; modules with other widths use flat vectors.
  typedef struct packed {
    logic [LANES_DEF-1:0]            nop;
    logic [LANES_DEF*DATA_W_DEF-1:0] data;
    logic [PC_W_DEF-1:0]             pc;
  } bundle_t;

endpackage

// File: rtl/vliw_pipe_entry.sv
// rtl/vliw_pipe_entry.sv - one bundle register with clear, load and sticky kill mask
module vliw_pipe_entry #(
  parameter int LANES  = 4,
  parameter int DATA_W = 64,
  parameter int PC_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [LANES-1:0]        kill,
  input  logic [LANES-1:0]        d_nop,
  input  logic [LANES*DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]         d_pc,
  output logic [LANES-1:0]        q_nop,
  output logic [LANES*DATA_W-1:0] q_data,
  output logic [PC_W-1:0]         q_pc
);

  // Clear only forces the nop mask; stale payload is harmless behind an all-nop mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_nop  <= '1;
      q_data <= '0;
      q_pc   <= '0;
    end else if (clear) begin
      q_nop  <= '1;
    end else if (load) begin
      q_nop  <= d_nop;
      q_data <= d_data;
      q_pc   <= d_pc;
    end else begin
      q_nop  <= q_nop | kill;
    end
  end

endmodule

// File: rtl/vliw_stage_skid_reg.sv
// rtl/vliw_stage_skid_reg.sv - elastic VLIW stage register with 2-entry skid, flush and lane kill
module vliw_stage_skid_reg
  import vliw_pipe_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_nop,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]         in_pc,
  input  logic [LANES-1:0]        kill_lane,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_nop,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [PC_W-1:0]         out_pc
);

  skid_state_t state, next_state;

  logic push, pop;
  logic main_load, main_clear, skid_load, skid_clear;
  logic [LANES-1:0]        main_kill;
  logic [LANES-1:0]        main_d_nop;
  logic [LANES*DATA_W-1:0] main_d_data;
  logic [PC_W-1:0]         main_d_pc;
  logic [LANES-1:0]        skid_nop;
  logic [LANES*DATA_W-1:0] skid_data;
  logic [PC_W-1:0]         skid_pc;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) next_state = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      next_state = ST_TWO;
          else if (pop && !push) next_state = ST_EMPTY;
        end
        ST_TWO:   if (pop) next_state = ST_ONE;
        default:  next_state = ST_EMPTY;
      endcase
    end
  end

  // Main reloads from the skid when draining TWO, otherwise straight from the input.
  always_comb begin
    main_load  = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (!flush) begin
      case (state)
        ST_EMPTY: main_load = push;
        ST_ONE: begin
          main_load = push & pop;
          skid_load = push & ~pop;
        end
        ST_TWO: begin
          main_load  = pop;
          skid_clear = pop;
        end
        default: main_load = 1'b0;
      endcase
    end else begin
      skid_clear = 1'b1;
    end
  end

  assign main_clear  = flush | (pop & (next_state == ST_EMPTY));
  assign main_kill   = kill_lane & {LANES{out_valid & ~pop}};
  assign main_d_nop  = (state == ST_TWO) ? skid_nop  : in_nop;
  assign main_d_data = (state == ST_TWO) ? skid_data : in_data;
  assign main_d_pc   = (state == ST_TWO) ? skid_pc   : in_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= next_state;
      out_valid <= (next_state != ST_EMPTY);
      in_ready  <= (next_state != ST_TWO);
    end
  end

  vliw_pipe_entry #(.LANES(LANES), .DATA_W(DATA_W), .PC_W(PC_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (main_clear),
    .load   (main_load),
    .kill   (main_kill),
    .d_nop  (main_d_nop),
    .d_data (main_d_data),
    .d_pc   (main_d_pc),
    .q_nop  (out_nop),
    .q_data (out_data),
    .q_pc   (out_pc)
  );

  vliw_pipe_entry #(.LANES(LANES), .DATA_W(DATA_W), .PC_W(PC_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (skid_clear),
    .load   (skid_load),
    .kill   ({LANES{1'b0}}),
    .d_nop  (in_nop),
    .d_data (in_data),
    .d_pc   (in_pc),
    .q_nop  (skid_nop),
    .q_data (skid_data),
    .q_pc   (skid_pc)
  );

endmodule

// File: tb/tb_vliw_stage_skid_reg.sv
// tb/tb_vliw_stage_skid_reg.sv - randomized bench for vliw_stage_skid_reg against a queue model
module tb_vliw_stage_skid_reg;
  import vliw_pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_nop = '0;
  logic [255:0] in_data = '0;
  logic [31:0]  in_pc = '0;
  logic [3:0]   kill_lane = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   out_nop;
  logic [255:0] out_data;
  logic [31:0]  out_pc;

  int n_vec = 0;
  int n_err = 0;
  bundle_t mq[$];

  always #5 clk = ~clk;

  vliw_stage_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nop    (in_nop),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .kill_lane (kill_lane),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_nop   (out_nop),
    .out_data  (out_data),
    .out_pc    (out_pc)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_outputs();
    chk("out_valid", {255'b0, out_valid}, {255'b0, mq.size() > 0});
    chk("in_ready", {255'b0, in_ready}, {255'b0, mq.size() < 2});
    if (mq.size() > 0) begin
      chk("out_nop", {252'b0, out_nop}, {252'b0, mq[0].nop});
      chk("out_data", out_data, mq[0].data);
      chk("out_pc", {224'b0, out_pc}, {224'b0, mq[0].pc});
    end else begin
      chk("empty_nop", {252'b0, out_nop}, {252'b0, NOP_ALL});
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at the next negedge.
  task automatic step(input logic iv, input logic [3:0] nop, input logic [31:0] pc,
                      input logic [3:0] kill, input logic ordy, input logic fl);
    bundle_t b;
    logic    push, pop;
    in_valid  = iv;
    in_nop    = nop;
    in_pc     = pc;
    in_data   = rand_data();
    kill_lane = kill;
    out_ready = ordy;
    flush     = fl;
    b.nop  = nop;
    b.data = in_data;
    b.pc   = pc;
    push = iv && (mq.size() < 2);
    pop  = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && !pop) mq[0].nop = mq[0].nop | kill;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(b);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {255'b0, out_valid}, 256'd0);
    chk("rst_ready", {255'b0, in_ready}, 256'd1);
    chk("rst_nop", {252'b0, out_nop}, {252'b0, NOP_ALL});
    chk("rst_data", out_data, 256'd0);
    chk("rst_pc", {224'b0, out_pc}, 256'd0);

    // single push, latency one
    step(1'b1, 4'b0000, 32'h100, 4'b0, 1'b0, 1'b0);
    chk("t1_pc", {224'b0, out_pc}, 256'h100);
    step(1'b0, 4'b0000, 32'h0, 4'b0, 1'b1, 1'b0);

    // streaming at full rate
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'($urandom), 32'h100 + 32'(4 * i), 4'b0, 1'b1, 1'b0);
    step(1'b0, 4'b0, 32'h0, 4'b0, 1'b1, 1'b0);

    // backpressure fills the skid, then drains in order
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b0000, 32'h200 + 32'(4 * i), 4'b0, 1'b0, 1'b0);
    chk("t3_ready", {255'b0, in_ready}, 256'd0);
    chk("t3_head", {224'b0, out_pc}, 256'h200);
    step(1'b0, 4'b0, 32'h0, 4'b0, 1'b1, 1'b0);
    chk("t3_second", {224'b0, out_pc}, 256'h204);
    step(1'b0, 4'b0, 32'h0, 4'b0, 1'b1, 1'b0);

    // flush in TWO with a simultaneous push
    step(1'b1, 4'b0000, 32'h300, 4'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 32'h304, 4'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 32'hdead, 4'b0, 1'b0, 1'b1);
    chk("t4_valid", {255'b0, out_valid}, 256'd0);
    chk("t4_nop", {252'b0, out_nop}, 256'hf);
    step(1'b0, 4'b0, 32'h0, 4'b0, 1'b1, 1'b0);
    chk("t4_still_empty", {255'b0, out_valid}, 256'd0);

    // sticky kill on the held bundle only
    step(1'b1, 4'b0000, 32'h400, 4'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 32'h404, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 32'h0, 4'b1100, 1'b0, 1'b0);
    step(1'b0, 4'b0, 32'h0, 4'b0000, 1'b0, 1'b0);
    chk("t5_killed", {252'b0, out_nop}, 256'hc);
    step(1'b0, 4'b0, 32'h0, 4'b0, 1'b1, 1'b0);
    chk("t5_next_pc", {224'b0, out_pc}, 256'h404);
    chk("t5_next_nop", {252'b0, out_nop}, 256'h0);
    step(1'b0, 4'b0, 32'h0, 4'b0, 1'b1, 1'b0);

    // asynchronous reset while full
    step(1'b1, 4'b0011, 32'h500, 4'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0101, 32'h504, 4'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", {255'b0, out_valid}, 256'd0);
    chk("t6_ready", {255'b0, in_ready}, 256'd1);
    chk("t6_nop", {252'b0, out_nop}, 256'hf);
    chk("t6_pc", {224'b0, out_pc}, 256'd0);
    chk("t6_data", out_data, 256'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
